// File: rtl/n_serial_rx_framer_if.sv
// rtl/n_serial_rx_framer_if.sv - serial wire input and decoded frame event outputs
interface n_serial_rx_framer_if;
    logic rx;
    logic rx_start;
    logic rx_strobe;
    logic rx_data;
    logic rx_stop;
    logic rx_error;

    modport master (
        input  rx,
        output rx_start,
        output rx_strobe,
        output rx_data,
        output rx_stop,
        output rx_error
    );

    modport slave (
        output rx,
        input  rx_start,
        input  rx_strobe,
        input  rx_data,
        input  rx_stop,
        input  rx_error
    );
endinterface

// File: rtl/n_serial_rx_framer.sv
// rtl/n_serial_rx_framer.sv - pulse-width serial frame decoder (start, data strobes, stop, error)
module n_serial_rx_framer #(
    parameter int SAMPLE_POINT = 50,
    parameter int LOW_MAX      = 100,
    parameter int IDLE_TIMEOUT = 125
) (
    input  logic                   clk,
    input  logic                   reset,
    n_serial_rx_framer_if.master   bus
);
    localparam logic [7:0] SP   = 8'(SAMPLE_POINT);
    localparam logic [7:0] LMAX = 8'(LOW_MAX);
    localparam logic [7:0] ITO  = 8'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {RECOVER, IDLE, LOW, HIGH} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       rx_q;
    logic       pend_flag, pend_flag_nxt;
    logic       pend_bit, pend_bit_nxt;
    logic       start_r, strobe_r, data_r, stop_r, error_r;
    logic       start_nxt, strobe_nxt, data_nxt, stop_nxt, error_nxt;
    logic       fall, rise;

    assign fall = rx_q & ~bus.rx;
    assign rise = ~rx_q & bus.rx;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = fall ? 8'd0 : ((cnt == 8'hff) ? cnt : cnt + 8'd1);
        pend_flag_nxt = pend_flag;
        pend_bit_nxt  = pend_bit;
        start_nxt     = 1'b0;
        strobe_nxt    = 1'b0;
        data_nxt      = data_r;
        stop_nxt      = 1'b0;
        error_nxt     = 1'b0;

        // A short-low bit has already risen by the sample point, so sampling runs in HIGH too
        if ((state == LOW || state == HIGH) && cnt == SP) begin
            pend_bit_nxt  = bus.rx;
            pend_flag_nxt = 1'b1;
        end

        case (state)
            RECOVER: begin
                if (!bus.rx) begin
                    cnt_nxt = 8'd0;
                end else if (cnt >= ITO) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (fall) begin
                    start_nxt     = 1'b1;
                    pend_flag_nxt = 1'b0;
                    state_nxt     = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    state_nxt = HIGH;
                end else if (!bus.rx && cnt == LMAX) begin
                    error_nxt = 1'b1;
                    state_nxt = RECOVER;
                end
            end
            HIGH: begin
                if (fall) begin
                    if (cnt < SP) begin
                        error_nxt = 1'b1;
                        state_nxt = RECOVER;
                    end else begin
                        // The bit just starting is not known yet; release the previous one
                        if (pend_flag) begin
                            strobe_nxt = 1'b1;
                            data_nxt   = pend_bit;
                        end
                        state_nxt = LOW;
                    end
                end else if (cnt == ITO) begin
                    if (pend_bit) stop_nxt  = 1'b1;
                    else          error_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = RECOVER;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RECOVER;
            cnt       <= 8'd0;
            rx_q      <= 1'b1;
            pend_flag <= 1'b0;
            pend_bit  <= 1'b0;
            start_r   <= 1'b0;
            strobe_r  <= 1'b0;
            data_r    <= 1'b0;
            stop_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rx_q      <= bus.rx;
            pend_flag <= pend_flag_nxt;
            pend_bit  <= pend_bit_nxt;
            start_r   <= start_nxt;
            strobe_r  <= strobe_nxt;
            data_r    <= data_nxt;
            stop_r    <= stop_nxt;
            error_r   <= error_nxt;
        end
    end

    assign bus.rx_start  = start_r;
    assign bus.rx_strobe = strobe_r;
    assign bus.rx_data   = data_r;
    assign bus.rx_stop   = stop_r;
    assign bus.rx_error  = error_r;
endmodule
